// File: rtl/mpc_kob.sv
// mpc_kob_pkg: response types shared by the keep-order buffer and its neighbours.
//
// mpc_kob: per-channel keep-order buffer. Grants a rob_id for every load the
// channel issues, collects out-of-order bank responses into the matching slot,
// and hands them back to the channel strictly in issue order.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   alloc_valid_i    channel wants a slot for a new load
//   alloc_ready_o    a free slot exists
//   alloc_id_o       rob_id granted (tail slot), valid while alloc_ready_o
//   rsp_valid_i      bank response valid (always accepted)
//   rsp_i            bank response {channel_id, rob_id, rdata}
//   chan_rsp_valid_o head slot is allocated and filled
//   chan_rsp_ready_i channel accepts the head response
//   chan_rsp_o       head response data (zero while not valid)
//   count_o          slots allocated and not yet popped
//   err_o            sticky: a fill was dropped
package mpc_kob_pkg;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic [1:0]        channel_id;
    logic [2:0]        rob_id;
    logic [DATA_W-1:0] rdata;
  } rc_rsp_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
  } channel_rsp_t;
endpackage

module mpc_kob
  import mpc_kob_pkg::*;
#(
  parameter int         KOB_SIZE   = 8,
  parameter logic [1:0] CHANNEL_ID = 2'd0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         alloc_valid_i,
  output logic         alloc_ready_o,
  output logic [2:0]   alloc_id_o,
  input  logic         rsp_valid_i,
  input  rc_rsp_t      rsp_i,
  output logic         chan_rsp_valid_o,
  input  logic         chan_rsp_ready_i,
  output channel_rsp_t chan_rsp_o,
  output logic [3:0]   count_o,
  output logic         err_o
);

  localparam int         PTR_W  = (KOB_SIZE > 1) ? $clog2(KOB_SIZE) : 1;
  localparam logic [3:0] SIZE_C = 4'(KOB_SIZE);

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [3:0]          count_q, count_d;
  logic [KOB_SIZE-1:0] alloc_q, alloc_d;
  logic [KOB_SIZE-1:0] filled_q, filled_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q [KOB_SIZE];

  logic                alloc_fire;
  logic                pop_fire;
  logic                fill_hit;
  logic                fill_ok;
  logic [PTR_W-1:0]    fill_id;

  // Outputs are decoded from registered state only.
  assign alloc_ready_o    = (count_q != SIZE_C);
  assign alloc_id_o       = 3'(tail_q);
  assign chan_rsp_valid_o = alloc_q[head_q] && filled_q[head_q];
  assign chan_rsp_o.rdata = chan_rsp_valid_o ? data_q[head_q] : '0;
  assign count_o          = count_q;
  assign err_o            = err_q;

  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  assign pop_fire   = chan_rsp_valid_o && chan_rsp_ready_i;
  assign fill_hit   = rsp_valid_i && (rsp_i.channel_id == CHANNEL_ID);
  assign fill_id    = rsp_i.rob_id[PTR_W-1:0];

  // A fill is legal only into a slot that was already allocated and still
  // empty before this edge. That makes a fill racing its own allocation, or
  // racing the pop of an already-filled head, a dropped error.
  assign fill_ok = fill_hit
                && ({1'b0, rsp_i.rob_id} < SIZE_C)
                && alloc_q[fill_id]
                && !filled_q[fill_id];

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    alloc_d  = alloc_q;
    filled_d = filled_q;
    err_d    = err_q;

    if (alloc_fire) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + PTR_W'(1);
    end

    if (fill_ok) begin
      filled_d[fill_id] = 1'b1;
    end
    if (fill_hit && !fill_ok) begin
      err_d = 1'b1;
    end

    // Head and tail only coincide when empty (no pop) or full (no alloc),
    // so the pop never collides with the alloc update above.
    if (pop_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + PTR_W'(1);
    end

    case ({alloc_fire, pop_fire})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

  // Data storage; contents are qualified by alloc/filled, so no reset.
  always_ff @(posedge clk_i) begin
    if (fill_ok) begin
      data_q[fill_id] <= rsp_i.rdata;
    end
  end

endmodule

// File: tb/tb_mpc_kob.sv
module tb_mpc_kob;
  import mpc_kob_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         alloc_valid = 1'b0;
  logic         alloc_ready;
  logic [2:0]   alloc_id;
  logic         rsp_valid = 1'b0;
  rc_rsp_t      rsp = '0;
  logic         chan_valid;
  logic         chan_ready = 1'b0;
  channel_rsp_t chan_rsp;
  logic [3:0]   count;
  logic         err;

  always #5 clk = ~clk;

  mpc_kob #(.KOB_SIZE(8), .CHANNEL_ID(2'd0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .alloc_valid_i   (alloc_valid),
    .alloc_ready_o   (alloc_ready),
    .alloc_id_o      (alloc_id),
    .rsp_valid_i     (rsp_valid),
    .rsp_i           (rsp),
    .chan_rsp_valid_o(chan_valid),
    .chan_rsp_ready_i(chan_ready),
    .chan_rsp_o      (chan_rsp),
    .count_o         (count),
    .err_o           (err)
  );

  // Reference model: the list of outstanding loads in issue order, each with
  // the data its response carried once it has arrived.
  typedef struct {
    logic [2:0]   id;
    logic [127:0] data;
    bit           filled;
  } ent_t;

  ent_t         ob[$];
  logic [127:0] exp_q[$];
  logic [2:0]   next_id = 3'd0;
  bit           err_exp = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (ob.size() > 0) && ob[0].filled;
    chk("count", 128'(count), 128'(ob.size()));
    chk("alloc_ready", 128'(alloc_ready), 128'(ob.size() < 8));
    chk("alloc_id", 128'(alloc_id), 128'(next_id));
    chk("err", 128'(err), 128'(err_exp));
    chk("chan_valid", 128'(chan_valid), 128'(exp_valid));
  endtask

  // Drive one cycle of stimulus, advance the model to what the DUT must hold
  // after the next edge, then check just after that edge.
  task automatic step(bit av, bit rv, logic [1:0] ch, logic [2:0] id,
                      logic [127:0] d, bit rdy);
    bit   pop;
    bit   can_alloc;
    int   idx;
    ent_t e;
    alloc_valid = av;
    rsp_valid   = rv;
    rsp         = '{channel_id: ch, rob_id: id, rdata: d};
    chan_ready  = rdy;
    pop       = (ob.size() > 0) && ob[0].filled && rdy;
    can_alloc = ob.size() < 8;
    if (rv && ch == 2'd0) begin
      idx = -1;
      foreach (ob[i]) if (ob[i].id == id && !ob[i].filled) idx = i;
      if (idx < 0) err_exp = 1'b1;
      else begin
        e = ob[idx];
        e.filled = 1'b1;
        e.data = d;
        ob[idx] = e;
      end
    end
    if (pop) begin
      exp_q.push_back(ob[0].data);
      void'(ob.pop_front());
    end
    if (av && can_alloc) begin
      ob.push_back('{id: next_id, data: '0, filled: 1'b0});
      next_id = next_id + 3'd1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(bit rdy);
    step(1'b0, 1'b0, 2'd0, 3'd0, rnd128(), rdy);
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    rsp_valid   = 1'b0;
    chan_ready  = 1'b0;
    rst = 1'b1;
    ob.delete();
    exp_q.delete();
    next_id = 3'd0;
    err_exp = 1'b0;
    #1;
    check_outputs();
    chk("reset_data", chan_rsp.rdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted response, and checks that
  // a stalled response holds and that idle data reads as zero.
  initial begin : monitor
    bit           prev_hold;
    logic [127:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (!chan_valid) chk("idle_data", chan_rsp.rdata, '0);
        if (prev_hold) begin
          chk("hold_valid", 128'(chan_valid), 128'(1));
          chk("hold_data", chan_rsp.rdata, prev_data);
        end
        if (chan_valid && chan_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_data: got unexpected pop %0h, required no pop", chan_rsp.rdata);
          end else begin
            chk("pop_data", chan_rsp.rdata, exp_q.pop_front());
          end
        end
        prev_hold = chan_valid && !chan_ready;
        prev_data = chan_rsp.rdata;
      end
    end
  end

  initial begin : driver
    logic [127:0] d;
    #2;
    do_reset();

    // In-order return of out-of-order fills.
    repeat (3) step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b1);
    step(1'b0, 1'b1, 2'd0, 3'd2, 128'hA, 1'b1);
    step(1'b0, 1'b1, 2'd0, 3'd0, 128'hB, 1'b1);
    step(1'b0, 1'b1, 2'd0, 3'd1, 128'hC, 1'b1);
    repeat (3) idle(1'b1);

    // Full: pop with alloc held gets no alloc; ready returns next cycle, id wraps.
    do_reset();
    repeat (8) step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 3'd0, rnd128(), 1'b1);
    step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 2'd0, 3'(i), rnd128(), 1'b1);
    step(1'b0, 1'b1, 2'd0, 3'd0, rnd128(), 1'b1);
    repeat (3) idle(1'b1);

    // Fill before allocation: dropped, error sticky until reset.
    do_reset();
    step(1'b0, 1'b1, 2'd0, 3'd5, rnd128(), 1'b1);
    repeat (3) idle(1'b1);
    do_reset();

    // Duplicate fill: dropped, original data kept.
    step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 3'd0, 128'h1111, 1'b0);
    step(1'b0, 1'b1, 2'd0, 3'd0, 128'h2222, 1'b0);
    idle(1'b1);

    // Fill racing its own allocation.
    do_reset();
    step(1'b1, 1'b1, 2'd0, 3'd0, rnd128(), 1'b1);
    idle(1'b1);

    // Fill into the head being popped: error, pop still completes.
    do_reset();
    step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 3'd0, 128'h3333, 1'b0);
    step(1'b0, 1'b1, 2'd0, 3'd0, 128'h4444, 1'b1);
    idle(1'b1);

    // Another channel's response is ignored.
    do_reset();
    step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b1);
    step(1'b0, 1'b1, 2'd1, 3'd0, rnd128(), 1'b1);
    idle(1'b1);

    // Stall the head for 4 cycles, then a single pop.
    step(1'b0, 1'b1, 2'd0, 3'd0, rnd128(), 1'b0);
    repeat (4) idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset with entries outstanding; a late response then errors.
    do_reset();
    repeat (4) step(1'b1, 1'b0, 2'd0, 3'd0, '0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 3'd0, rnd128(), 1'b0);
    do_reset();
    step(1'b0, 1'b1, 2'd0, 3'd2, rnd128(), 1'b1);
    do_reset();

    // Random traffic: legal fills in any order, stray other-channel responses.
    for (int c = 0; c < 1500; c++) begin
      bit         av, rv, rdy;
      logic [1:0] ch;
      logic [2:0] id;
      int         uf[$];
      uf.delete();
      av  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = 1'b0;
      ch  = 2'd0;
      id  = 3'd0;
      foreach (ob[i]) if (!ob[i].filled) uf.push_back(i);
      if (uf.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv = 1'b1;
        id = ob[uf[$urandom_range(0, uf.size() - 1)]].id;
      end else if ($urandom_range(0, 3) == 0) begin
        rv = 1'b1;
        ch = 2'($urandom_range(1, 3));
        id = 3'($urandom_range(0, 7));
      end
      step(av, rv, ch, id, rnd128(), rdy);
    end

    // Drain everything still outstanding.
    for (int g = 0; g < 40 && ob.size() > 0; g++) begin
      int k;
      k = -1;
      foreach (ob[i]) if (!ob[i].filled && k < 0) k = i;
      if (k >= 0) step(1'b0, 1'b1, 2'd0, ob[k].id, rnd128(), 1'b1);
      else idle(1'b1);
    end
    idle(1'b1);
    chk("drained", 128'(ob.size()), 128'(0));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpc_kob.md
# mpc_kob

Per-channel keep-order buffer (KOB) for the multi-port cache. It allocates a `rob_id` for every load the channel issues toward the banks. It collects the `rc_rsp_t` responses, which arrive out of order from any bank, and returns them to the channel as `channel_rsp_t` strictly in issue order. One instance sits on the response side of each channel port. It is the return path for requests that leave the channel as `bank_req_t`.

## Interface
- `KOB_SIZE`, 8: number of entries; power of two, 2..8, limited by the 3-bit `rob_id`.
- `CHANNEL_ID`, 2'd0: channel this instance serves; compared against `rc_rsp_t.channel_id`.

Ports:
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `alloc_valid_i`  in  1  channel issues a load this cycle and needs a slot.
- `alloc_ready_o`  out  1  a free slot exists.
- `alloc_id_o`  out  3  `rob_id` granted; valid while `alloc_ready_o`.
- `rsp_valid_i`  in  1  bank response valid; always accepted, there is no ready.
- `rsp_i`  in  `rc_rsp_t`  `{channel_id, rob_id, rdata}`.
- `chan_rsp_valid_o`  out  1  in-order response available.
- `chan_rsp_ready_i`  in  1  channel accepts the response.
- `chan_rsp_o`  out  `channel_rsp_t`  response data.
- `count_o`  out  4  entries allocated and not yet popped, 0..KOB_SIZE.
- `err_o`  out  1  sticky protocol error.

## Operation
State:
- `head` and `tail`, each $clog2(KOB_SIZE) bits, both wrap modulo KOB_SIZE.
- `count`, 4 bits.
- Per-slot `alloc` and `filled` bits.
- Per-slot 128-bit data register.

Allocation:
- `alloc_ready_o = (count != KOB_SIZE)`.
- `alloc_id_o = tail`, zero-extended to 3 bits.
- On `alloc_valid_i && alloc_ready_o`:
  - set `alloc[tail]`, clear `filled[tail]`;
  - `tail <= tail+1` (wraps).

Fill, when `rsp_valid_i && rsp_i.channel_id == CHANNEL_ID`:
- Let `id = rsp_i.rob_id`, truncated to the pointer width.
- If `rob_id >= KOB_SIZE`, or `!alloc[id]`, or `filled[id]`: drop the response and set `err_o`.
- Otherwise write the data register and set `filled[id]`.
- A mismatching `channel_id` is ignored silently; it belongs to another channel.

Drain:
- `chan_rsp_valid_o = alloc[head] && filled[head]`.
- `chan_rsp_o.rdata` = data[head] while valid, otherwise 0.
- On `chan_rsp_valid_o && chan_rsp_ready_i`:
  - clear `alloc[head]` and `filled[head]`;
  - `head <= head+1` (wraps).
- Valid and data stay stable until accepted.

Count:
- `count` increments on alloc only, decrements on pop only, and is unchanged when both happen in the same cycle.
- `count_o = count`.

Error:
- `err_o` is set by any dropped fill.
- It is cleared only by reset.

## Timing
- Reset asynchronously forces:
  - `head = tail = count = 0`;
  - all `alloc` and `filled` bits cleared;
  - `err_o = 0`.
- Resulting output values:
  - `alloc_ready_o = 1`, `alloc_id_o = 0`;
  - `chan_rsp_valid_o = 0`, `chan_rsp_o = 0`;
  - `count_o = 0`.
- Data registers are not reset.
- Reset mid-operation discards all outstanding entries; late bank responses after reset hit unallocated slots and set `err_o`.
- All outputs are decoded from registers only, with no combinational input-to-output path.
- Fill-to-output latency is 1 cycle: a response for the head slot sampled at edge N gives `chan_rsp_valid_o` = 1 after edge N.
- Throughput is one alloc, one fill and one pop per cycle, simultaneously.

Boundary conditions:
- **Full**: `alloc_ready_o = 0` even when a pop happens in the same cycle; there is no bypass. Ready rises the cycle after the pop.
- **Empty**: `alloc[head] = 0`, so `chan_rsp_valid_o = 0`.
- **Fill into the slot being popped in the same cycle**: that slot is already filled, so this is an error; the pop still completes.
- **Fill into a slot allocated in the same cycle**: error, because `alloc` is sampled before the update.
- **Wrap-around**: ids are reused in order 0..KOB_SIZE-1, 0, ...

## Test plan
- Reset, then 3 allocs → ids 0, 1, 2 and `count_o` = 3; fill 2, 0, 1 with 0xA, 0xB, 0xC → channel receives 0xB, 0xC, 0xA in issue order. `chan_rsp_valid_o` rises 1 cycle after the id-0 fill.
- 8 allocs → `alloc_ready_o` = 0 and `count_o` = 8. Pop with alloc_valid held → no alloc that cycle; next cycle ready = 1 and id = 0 is granted (wrap).
- Fill id 5 before allocation, then duplicate fill of an allocated id → both dropped, `err_o` = 1 and stays set until reset.
- Fill with `channel_id` = 1 while `CHANNEL_ID` = 0 → no state change, `err_o` stays 0.
- Head filled with `chan_rsp_ready_i` = 0 for 4 cycles → valid and data held constant; then ready = 1 → single pop with `count_o` decremented once.
- Assert reset with 4 entries outstanding → all outputs return to their reset values immediately; a subsequent fill for id 2 sets `err_o`.
